// File: rtl/alarm_pkg.sv
// Shared state encoding, parameter defaults and sizing helper for the alarm ringer.
package alarm_pkg;

    localparam int unsigned TONE_DIV_DEF         = 4;
    localparam int unsigned RING_TIMEOUT_SEC_DEF = 60;
    localparam int unsigned SNOOZE_SEC_DEF       = 300;
    localparam int unsigned MAX_SNOOZE_DEF       = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2,
        S_DONE   = 2'd3
    } ring_state_e;

    // Bits needed to hold the larger of the two second counts inclusive.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Registers a level input once and flags the cycle in which it goes from low to high.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings on alarm match, handles snooze/stop buttons and timeouts, gates the buzzer tone.
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_DIV         = TONE_DIV_DEF,
    parameter int unsigned RING_TIMEOUT_SEC = RING_TIMEOUT_SEC_DEF,
    parameter int unsigned SNOOZE_SEC       = SNOOZE_SEC_DEF,
    parameter int unsigned MAX_SNOOZE       = MAX_SNOOZE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_trig,
    input  logic       sec_tick,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ring_led,
    output logic       snoozing,
    output logic [2:0] snooze_cnt
);

    localparam int unsigned TMR_W  = timer_width(RING_TIMEOUT_SEC, SNOOZE_SEC);
    localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [TMR_W-1:0]  RING_LAST = TMR_W'(RING_TIMEOUT_SEC - 1);
    localparam logic [TMR_W-1:0]  SNZ_LAST  = TMR_W'(SNOOZE_SEC - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [2:0]        MAX_CNT   = 3'(MAX_SNOOZE);

    logic trig_rise, snooze_rise, stop_rise;

    edge_rise u_trig_edge   (.clk(clk), .reset(reset), .d_i(alarm_trig), .rise_o(trig_rise));
    edge_rise u_snooze_edge (.clk(clk), .reset(reset), .d_i(snooze_btn), .rise_o(snooze_rise));
    edge_rise u_stop_edge   (.clk(clk), .reset(reset), .d_i(stop_btn),   .rise_o(stop_rise));

    ring_state_e       state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              beep_q, beep_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;
    logic              buzzer_q, ring_q, snoozing_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        beep_d     = beep_q;
        tone_cnt_d = (tone_cnt_q == TONE_LAST) ? '0 : tone_cnt_q + 1'b1;
        tone_d     = (tone_cnt_q == TONE_LAST) ? ~tone_q : tone_q;

        case (state_q)
            S_IDLE: begin
                if (trig_rise) begin
                    state_d = S_RING;
                    cnt_d   = '0;
                    timer_d = '0;
                    beep_d  = 1'b1;
                end
            end
            S_RING: begin
                // Stop wins over a simultaneous snooze; a snooze at the limit falls through to the timer.
                if (stop_rise) begin
                    state_d = S_DONE;
                end else if (snooze_rise && (cnt_q < MAX_CNT)) begin
                    state_d = S_SNOOZE;
                    cnt_d   = cnt_q + 3'd1;
                    timer_d = '0;
                end else if (sec_tick) begin
                    if (timer_q == RING_LAST) begin
                        timer_d = '0;
                        if (cnt_q < MAX_CNT) begin
                            state_d = S_SNOOZE;
                            cnt_d   = cnt_q + 3'd1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                        beep_d  = ~beep_q;
                    end
                end
            end
            S_SNOOZE: begin
                if (stop_rise) begin
                    state_d = S_DONE;
                end else if (sec_tick) begin
                    if (timer_q == SNZ_LAST) begin
                        state_d = S_RING;
                        timer_d = '0;
                        beep_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!alarm_trig) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            beep_q     <= 1'b0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            buzzer_q   <= 1'b0;
            ring_q     <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            beep_q     <= beep_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            buzzer_q   <= (state_d == S_RING) && beep_d && tone_d;
            ring_q     <= (state_d == S_RING);
            snoozing_q <= (state_d == S_SNOOZE);
        end
    end

    assign buzzer     = buzzer_q;
    assign ring_led   = ring_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = cnt_q;

endmodule
